led_driver_module: RTL and testbench
====================================

LED_DRIVER_MODULE -- requirements
Module: led_driver_module

Interface
REQ-001 Parameter: TICK_DIV, default 50000, clock cycles per 1 ms timebase tick (minimum 2).
REQ-002 Parameter: BLINK_MS, default 250, ticks per blink half-period (minimum 1).
REQ-003 Parameter: BREATHE_MS, default 32, ticks per breathe level step (minimum 1).
REQ-004 Parameter: ACTIVE_LOW, default 1; 1 = LED lit when the pin is 0.
REQ-005 CLK  input  1  single clock; all logic on the rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 Cmd_Valid  input  1  command present.
REQ-008 Cmd_Ready  output  1  command can be accepted this cycle.
REQ-009 Cmd_Chan  input  3  target channel; 4 Up, 3 Down, 2 Left, 1 Right, 0 Middle.
REQ-010 Cmd_Mode  input  2  00 off, 01 on, 10 blink, 11 breathe.
REQ-011 Cmd_Level  input  4  brightness for on/blink modes; 0 = dark, 15 = full.
REQ-012 Cmd_Err  output  1  one-cycle pulse when an accepted command has Cmd_Chan > 4.
REQ-013 LED_Out  output  5  LED pins; registered; bit order as Cmd_Chan.

Function
REQ-014 The block SHALL accept a command on every rising edge where Cmd_Valid and Cmd_Ready are both 1.
REQ-015 After reset is released, Cmd_Ready SHALL stay 1 continuously; there is no backpressure.
REQ-016 An accepted command with Cmd_Chan 0..4 SHALL load that channel's mode and level registers; other channels SHALL be unchanged.
REQ-017 An accepted command with Cmd_Chan 5..7 SHALL change no state and SHALL pulse Cmd_Err for exactly the following cycle.
REQ-018 Timebase: tick_cnt SHALL count 0..TICK_DIV-1 and wrap; a tick SHALL fire on the cycle tick_cnt == TICK_DIV-1.
REQ-019 Blink: a shared counter SHALL count ticks and toggle blink_phase every BLINK_MS ticks, then restart at 0.
REQ-020 Breathe: a shared 4-bit breathe_lvl SHALL step by 1 every BREATHE_MS ticks, moving 0 -> 15 -> 0 as a triangle.
REQ-021 Breathe direction SHALL reverse on reaching 15 (next value 14) and on reaching 0 (next value 1); the endpoint SHALL be held for one step only.
REQ-022 PWM: a free-running 4-bit pwm_cnt SHALL increment every clock, giving a 16-cycle period.
REQ-023 Lit decision for level L: lit = (L == 15) or (pwm_cnt < L).
REQ-024 Per-channel lit source by mode: off -> never lit; on -> Cmd_Level; blink -> Cmd_Level when blink_phase = 1, otherwise dark; breathe -> breathe_lvl, with Cmd_Level ignored.
REQ-025 LED_Out[i] SHALL be the registered lit value, inverted when ACTIVE_LOW = 1.
REQ-026 Latency: a command accepted at edge N SHALL first affect LED_Out at edge N+1.
REQ-027 Shared timebases SHALL NOT restart on commands, so all blinking and breathing channels stay phase-aligned.
REQ-028 A command arriving on the same cycle as a tick or phase toggle SHALL take the post-toggle phase; neither event SHALL be lost.
REQ-029 A repeated command to the same channel SHALL simply overwrite that channel's registers; it SHALL have no other effect.

Reset
REQ-030 While RST = 1 at an edge, the block SHALL clear: all channel modes to off, all levels to 0, tick_cnt, blink counter, blink_phase, pwm_cnt and breathe_lvl to 0, and breathe direction to up.
REQ-031 Reset outputs: LED_Out = 5'b11111 when ACTIVE_LOW = 1, else 5'b00000; Cmd_Ready = 0; Cmd_Err = 0.
REQ-032 Cmd_Ready SHALL rise on the first edge with RST = 0.
REQ-033 Reset asserted mid-operation SHALL override any command accepted on the same edge.

Verification (TICK_DIV=4, BLINK_MS=2, BREATHE_MS=1, ACTIVE_LOW=1)
REQ-034 Reset, then no commands for 200 cycles -> LED_Out = 5'b11111 throughout; Cmd_Ready = 1 from the first cycle after reset.
REQ-035 Command chan 0, mode on, level 15 at edge N -> LED_Out[0] = 0 from edge N+1 onward; all other bits stay 1.
REQ-036 Command chan 4, mode on, level 4 -> LED_Out[4] is 0 for exactly 4 of every 16 cycles.
REQ-037 Commands chan 1 and chan 2, both blink level 15, sent 3 cycles apart -> both bits toggle together every 8 cycles.
REQ-038 Command chan 3, mode breathe -> breathe_lvl steps 0,1,...,15,14,...,0,1 every 4 cycles, and the duty of LED_Out[3] tracks it.
REQ-039 Command with chan 6 -> Cmd_Err is 1 for one cycle and LED_Out is unchanged; RST pulsed while LEDs are blinking -> all outputs return to 1 on the next edge.

Source files
------------

// File: rtl/led_driver_module.sv
// Five-channel LED driver: per-channel off/on/blink/breathe modes with
// 4-bit PWM brightness, all channels sharing one 1 ms timebase so that
// blinking and breathing channels stay phase-aligned.
module led_driver_module #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned BREATHE_MS = 32,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [2:0] Cmd_Chan,
  input  logic [1:0] Cmd_Mode,
  input  logic [3:0] Cmd_Level,
  output logic       Cmd_Err,
  output logic [4:0] LED_Out
);

  localparam int unsigned TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned BW = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;
  localparam int unsigned RW = (BREATHE_MS > 1) ? $clog2(BREATHE_MS) : 1;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  localparam logic [4:0] LED_DARK = (ACTIVE_LOW != 0) ? 5'b11111 : 5'b00000;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [RW-1:0] brth_cnt_q, brth_cnt_d;
  logic [3:0]    brth_lvl_q, brth_lvl_d;
  logic          brth_up_q, brth_up_d;
  logic [3:0]    pwm_cnt_q;

  logic [1:0]    mode_q  [5];
  logic [3:0]    level_q [5];
  logic          ready_q;
  logic          err_q;
  logic [4:0]    led_q, led_d;
  logic [3:0]    src_lvl [5];
  logic [4:0]    lit;

  logic accept;
  logic chan_ok;

  assign accept    = Cmd_Valid & ready_q;
  assign chan_ok   = (Cmd_Chan <= 3'd4);
  assign Cmd_Ready = ready_q;
  assign Cmd_Err   = err_q;
  assign LED_Out   = led_q;

  // Shared timebase: 1 ms tick, blink phase and breathe triangle.
  always_comb begin
    tick          = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    brth_cnt_d    = brth_cnt_q;
    brth_lvl_d    = brth_lvl_q;
    brth_up_d     = brth_up_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
      if (brth_cnt_q == RW'(BREATHE_MS - 1)) begin
        brth_cnt_d = '0;
        // Endpoints reverse direction immediately so 15 and 0 last one step.
        if (brth_up_q) begin
          if (brth_lvl_q == 4'd15) begin
            brth_lvl_d = 4'd14;
            brth_up_d  = 1'b0;
          end else begin
            brth_lvl_d = brth_lvl_q + 4'd1;
          end
        end else begin
          if (brth_lvl_q == 4'd0) begin
            brth_lvl_d = 4'd1;
            brth_up_d  = 1'b1;
          end else begin
            brth_lvl_d = brth_lvl_q - 4'd1;
          end
        end
      end else begin
        brth_cnt_d = brth_cnt_q + RW'(1);
      end
    end
  end

  // Timebase and PWM registers; never restarted by commands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      brth_cnt_q    <= '0;
      brth_lvl_q    <= '0;
      brth_up_q     <= 1'b1;
      pwm_cnt_q     <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      brth_cnt_q    <= brth_cnt_d;
      brth_lvl_q    <= brth_lvl_d;
      brth_up_q     <= brth_up_d;
      pwm_cnt_q     <= pwm_cnt_q + 4'd1;
    end
  end

  // Command intake: load the addressed channel, flag out-of-range channels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 5; i++) begin
        mode_q[i]  <= MODE_OFF;
        level_q[i] <= '0;
      end
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (accept && (Cmd_Chan == 3'(i))) begin
          mode_q[i]  <= Cmd_Mode;
          level_q[i] <= Cmd_Level;
        end
      end
      ready_q <= 1'b1;
      err_q   <= accept & ~chan_ok;
    end
  end

  // Per-channel brightness source and PWM lit decision; a dark source is level 0.
  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      src_lvl[i] = '0;
      case (mode_q[i])
        MODE_ON:      src_lvl[i] = level_q[i];
        MODE_BLINK:   src_lvl[i] = blink_phase_q ? level_q[i] : 4'd0;
        MODE_BREATHE: src_lvl[i] = brth_lvl_q;
        default:      src_lvl[i] = 4'd0;
      endcase
      lit[i] = (src_lvl[i] == 4'd15) || (pwm_cnt_q < src_lvl[i]);
    end
    led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  // Registered pin drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q <= LED_DARK;
    end else begin
      led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_led_driver_module.sv
// Bench for led_driver_module: a reference model derives the expected pins
// from elapsed cycles since reset and pushes them into a scoreboard queue;
// a monitor pops and compares on the falling edge.
module tb_led_driver_module;

  localparam int unsigned TD  = 4;
  localparam int unsigned BLM = 2;
  localparam int unsigned BRM = 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Cmd_Valid = 1'b0;
  logic       Cmd_Ready;
  logic [2:0] Cmd_Chan = '0;
  logic [1:0] Cmd_Mode = '0;
  logic [3:0] Cmd_Level = '0;
  logic       Cmd_Err;
  logic [4:0] LED_Out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0] led;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t sb[$];

  led_driver_module #(
    .TICK_DIV(TD),
    .BLINK_MS(BLM),
    .BREATHE_MS(BRM),
    .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Cmd_Valid(Cmd_Valid),
    .Cmd_Ready(Cmd_Ready),
    .Cmd_Chan(Cmd_Chan),
    .Cmd_Mode(Cmd_Mode),
    .Cmd_Level(Cmd_Level),
    .Cmd_Err(Cmd_Err),
    .LED_Out(LED_Out)
  );

  always #5 CLK = ~CLK;

  // Reference model: timebases as closed-form functions of elapsed cycles k.
  int unsigned k_m = 0;
  logic        ready_m = 1'b0;
  logic [1:0]  mode_m [5];
  logic [3:0]  lvl_m  [5];

  function automatic logic [3:0] breathe_at(int unsigned k);
    int unsigned p;
    p = ((k / TD) / BRM) % 30;
    return (p <= 15) ? 4'(p) : 4'(30 - p);
  endfunction

  function automatic logic blink_at(int unsigned k);
    return (((k / TD) / BLM) % 2) == 1;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    int   src;
    logic lit;
    if (RST) begin
      for (int i = 0; i < 5; i++) begin
        mode_m[i] = 2'b00;
        lvl_m[i]  = 4'd0;
      end
      k_m     = 0;
      ready_m = 1'b0;
      e.led   = 5'b11111;
      e.rdy   = 1'b0;
      e.err   = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        case (mode_m[i])
          2'b01:   src = lvl_m[i];
          2'b10:   src = blink_at(k_m) ? int'(lvl_m[i]) : 0;
          2'b11:   src = breathe_at(k_m);
          default: src = 0;
        endcase
        lit = (src == 15) || (int'(k_m % 16) < src);
        e.led[i] = ~lit;
      end
      e.rdy = 1'b1;
      e.err = Cmd_Valid && ready_m && (Cmd_Chan > 3'd4);
      if (Cmd_Valid && ready_m && (Cmd_Chan <= 3'd4)) begin
        mode_m[Cmd_Chan] = Cmd_Mode;
        lvl_m[Cmd_Chan]  = Cmd_Level;
      end
      ready_m = 1'b1;
      k_m++;
    end
    sb.push_back(e);
  end

  // Monitor: compare every registered output once per cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (LED_Out !== e.led) begin
        errors++;
        $display("FAIL led t=%0t got=%b exp=%b", $time, LED_Out, e.led);
      end
      checks++;
      if (Cmd_Ready !== e.rdy) begin
        errors++;
        $display("FAIL ready t=%0t got=%b exp=%b", $time, Cmd_Ready, e.rdy);
      end
      checks++;
      if (Cmd_Err !== e.err) begin
        errors++;
        $display("FAIL err t=%0t got=%b exp=%b", $time, Cmd_Err, e.err);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic issue(input logic [2:0] ch, input logic [1:0] md, input logic [3:0] lv);
    @(negedge CLK);
    Cmd_Valid = 1'b1;
    Cmd_Chan  = ch;
    Cmd_Mode  = md;
    Cmd_Level = lv;
    @(negedge CLK);
    Cmd_Valid = 1'b0;
  endtask

  initial begin
    int dark_cnt;
    idle(3);
    RST = 1'b0;
    idle(200);

    issue(3'd0, 2'b01, 4'd15);
    issue(3'd4, 2'b01, 4'd4);
    idle(2);
    dark_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (LED_Out[4] == 1'b0) dark_cnt++;
    end
    checks++;
    if (dark_cnt != 4) begin
      errors++;
      $display("FAIL duty4 lit_cycles=%0d exp=4", dark_cnt);
    end

    issue(3'd1, 2'b10, 4'd15);
    idle(2);
    issue(3'd2, 2'b10, 4'd15);
    idle(40);
    issue(3'd3, 2'b11, 4'd0);
    idle(130);
    issue(3'd6, 2'b01, 4'd15);
    idle(5);

    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST       = ($urandom_range(0, 299) == 0);
      Cmd_Valid = ($urandom_range(0, 3) == 0);
      Cmd_Chan  = 3'($urandom_range(0, 7));
      Cmd_Mode  = 2'($urandom_range(0, 3));
      Cmd_Level = 4'($urandom_range(0, 15));
    end
    @(negedge CLK);
    RST       = 1'b0;
    Cmd_Valid = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
